// File: rtl/dot_fp_pkg.sv
// Shared widths, types and element decode for the E4M3 minifloat dot-product datapath.
package dot_fp_pkg;

  localparam int unsigned def_exp_width = 4;
  localparam int unsigned def_man_width = 3;
  localparam int unsigned def_k         = 32;

  localparam int unsigned bit_width = 1 + def_exp_width + def_man_width;
  localparam int unsigned fi_width  = def_man_width + 2;
  localparam int unsigned fix_width = def_man_width + (1 << def_exp_width);
  localparam int unsigned prd_width = 2 * ((1 << def_exp_width) + def_man_width);
  localparam int unsigned out_width = prd_width + $clog2(def_k);

  typedef logic        [bit_width-1:0] elem_t;
  typedef logic signed [fix_width-1:0] fix_t;
  typedef logic signed [prd_width-1:0] prd_t;
  typedef logic signed [out_width-1:0] dp_t;

  // Value in units of the minimum subnormal; every encoding is finite.
  function automatic fix_t fp_to_fixed(input elem_t elem);
    logic [def_exp_width-1:0] e;
    logic [def_exp_width-1:0] sh;
    logic [fi_width-2:0]      mant;
    logic [fix_width-1:0]     mag;
    e    = elem[bit_width-2 -: def_exp_width];
    sh   = (e == '0) ? '0 : e - 1'b1;
    mant = {e != '0, elem[def_man_width-1:0]};
    mag  = fix_width'(mant) << sh;
    return elem[bit_width-1] ? -$signed(mag) : $signed(mag);
  endfunction

endpackage

// File: rtl/fp_mul_fixed.sv
// One lane: decodes two minifloat elements to fixed point and forms their exact signed product.
module fp_mul_fixed
  import dot_fp_pkg::*;
#(
  parameter  int unsigned exp_width = 4,
  parameter  int unsigned man_width = 3,
  localparam int unsigned elem_w    = 1 + exp_width + man_width,
  localparam int unsigned fix_w     = man_width + (1 << exp_width),
  localparam int unsigned prd_w     = 2 * ((1 << exp_width) + man_width)
) (
  input  logic              [elem_w-1:0] i_a,
  input  logic              [elem_w-1:0] i_b,
  output logic signed       [prd_w-1:0]  o_prd
);

  logic signed [fix_w-1:0] fix_a;
  logic signed [fix_w-1:0] fix_b;

  function automatic logic signed [fix_w-1:0] to_fixed(input logic [elem_w-1:0] elem);
    logic [exp_width-1:0] e;
    logic [exp_width-1:0] sh;
    logic [fix_w-1:0]     mag;
    e   = elem[elem_w-2 -: exp_width];
    sh  = (e == '0) ? '0 : e - 1'b1;
    mag = fix_w'({e != '0, elem[man_width-1:0]}) << sh;
    return elem[elem_w-1] ? -$signed(mag) : $signed(mag);
  endfunction

  always_comb begin
    fix_a = to_fixed(i_a);
    fix_b = to_fixed(i_b);
    o_prd = prd_w'(fix_a) * prd_w'(fix_b);
  end

endmodule

// File: rtl/dot_fp_stream.sv
// Streaming exact minifloat dot product: lanes elements per beat, three register stages,
// valid/ready on both sides with a single global enable.
module dot_fp_stream
  import dot_fp_pkg::*;
#(
  parameter  int unsigned exp_width = 4,
  parameter  int unsigned man_width = 3,
  parameter  int unsigned k         = 32,
  parameter  int unsigned lanes     = 8,
  localparam int unsigned elem_w    = 1 + exp_width + man_width,
  localparam int unsigned prd_w     = 2 * ((1 << exp_width) + man_width),
  localparam int unsigned out_w     = prd_w + $clog2(k),
  localparam int unsigned beats     = k / lanes,
  localparam int unsigned chunk_w   = $clog2(beats) + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_valid,
  output logic                      o_ready,
  input  logic [lanes*elem_w-1:0]   i_vec_a,
  input  logic [lanes*elem_w-1:0]   i_vec_b,
  output logic                      o_valid,
  input  logic                      i_ready,
  output logic signed [out_w-1:0]   o_dp,
  output logic [chunk_w-1:0]        o_chunk
);

  if (k % lanes != 0) begin : g_lanes_check
    $error("dot_fp_stream: lanes must divide k");
  end

  logic en;
  logic accept;
  logic load;

  logic signed [prd_w-1:0] prd [lanes];

  logic [chunk_w-1:0]      chunk_q, chunk_d;
  logic                    s1_valid_q, s1_valid_d;
  logic                    s1_first_q, s1_first_d;
  logic                    s1_last_q, s1_last_d;
  logic signed [prd_w-1:0] s1_prd_q [lanes];
  logic signed [prd_w-1:0] s1_prd_d [lanes];
  logic                    s2_valid_q, s2_valid_d;
  logic                    s2_first_q, s2_first_d;
  logic                    s2_last_q, s2_last_d;
  logic signed [out_w-1:0] s2_sum_q, s2_sum_d;
  logic signed [out_w-1:0] acc_q, acc_d;
  logic signed [out_w-1:0] dp_q, dp_d;
  logic                    o_valid_q, o_valid_d;
  logic signed [out_w-1:0] tree_sum;
  logic signed [out_w-1:0] acc_next;

  for (genvar g = 0; g < lanes; g++) begin : g_lane
    fp_mul_fixed #(
      .exp_width(exp_width),
      .man_width(man_width)
    ) u_mul (
      .i_a  (i_vec_a[g*elem_w +: elem_w]),
      .i_b  (i_vec_b[g*elem_w +: elem_w]),
      .o_prd(prd[g])
    );
  end

  always_comb begin
    en     = !o_valid_q || i_ready;
    accept = i_valid && en;

    chunk_d = chunk_q;
    if (accept) begin
      chunk_d = (chunk_q == chunk_w'(beats - 1)) ? '0 : chunk_q + 1'b1;
    end

    // Stage 1: per-lane products; data only captured on an accepted beat.
    s1_valid_d = s1_valid_q;
    s1_first_d = s1_first_q;
    s1_last_d  = s1_last_q;
    s1_prd_d   = s1_prd_q;
    if (en) begin
      s1_valid_d = i_valid;
      s1_first_d = (chunk_q == '0);
      s1_last_d  = (chunk_q == chunk_w'(beats - 1));
      if (i_valid) begin
        s1_prd_d = prd;
      end
    end

    tree_sum = '0;
    for (int unsigned i = 0; i < lanes; i++) begin
      tree_sum += out_w'(s1_prd_q[i]);
    end

    s2_valid_d = s2_valid_q;
    s2_first_d = s2_first_q;
    s2_last_d  = s2_last_q;
    s2_sum_d   = s2_sum_q;
    if (en) begin
      s2_valid_d = s1_valid_q;
      s2_first_d = s1_first_q;
      s2_last_d  = s1_last_q;
      s2_sum_d   = tree_sum;
    end

    acc_next = s2_first_q ? s2_sum_q : acc_q + s2_sum_q;
    acc_d    = acc_q;
    dp_d     = dp_q;
    load     = 1'b0;
    if (en && s2_valid_q) begin
      acc_d = acc_next;
      if (s2_last_q) begin
        dp_d = acc_next;
        load = 1'b1;
      end
    end

    // A fresh result may replace the one being handed off in the same cycle.
    if (load) begin
      o_valid_d = 1'b1;
    end else if (o_valid_q && i_ready) begin
      o_valid_d = 1'b0;
    end else begin
      o_valid_d = o_valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chunk_q    <= '0;
      s1_valid_q <= 1'b0;
      s1_first_q <= 1'b0;
      s1_last_q  <= 1'b0;
      for (int unsigned i = 0; i < lanes; i++) begin
        s1_prd_q[i] <= '0;
      end
      s2_valid_q <= 1'b0;
      s2_first_q <= 1'b0;
      s2_last_q  <= 1'b0;
      s2_sum_q   <= '0;
      acc_q      <= '0;
      dp_q       <= '0;
      o_valid_q  <= 1'b0;
    end else begin
      chunk_q    <= chunk_d;
      s1_valid_q <= s1_valid_d;
      s1_first_q <= s1_first_d;
      s1_last_q  <= s1_last_d;
      s1_prd_q   <= s1_prd_d;
      s2_valid_q <= s2_valid_d;
      s2_first_q <= s2_first_d;
      s2_last_q  <= s2_last_d;
      s2_sum_q   <= s2_sum_d;
      acc_q      <= acc_d;
      dp_q       <= dp_d;
      o_valid_q  <= o_valid_d;
    end
  end

  assign o_ready = en;
  assign o_valid = o_valid_q;
  assign o_dp    = dp_q;
  assign o_chunk = chunk_q;

endmodule
